// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants, state types and length clamp for the sorter/verifier pair
package sort_pkg;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int LEN_W     = 10;
   localparam int MEM_DEPTH = 256;
   localparam int ERR_W     = 8;
   localparam int SUM_W     = 16;

   typedef enum logic [2:0] {SORT_IDLE, SORT_LOAD, SORT_CMP, SORT_SWAP, SORT_DONE} sort_state_e;
   typedef enum logic [1:0] {VER_IDLE, VER_ISSUE, VER_DRAIN, VER_DONE} ver_state_e;

   // Lengths beyond the RAM depth scan the whole RAM exactly once.
   function automatic logic [ADDR_W:0] clamp_len(input logic [LEN_W-1:0] len);
      if (len > LEN_W'(MEM_DEPTH))
         return (ADDR_W+1)'(MEM_DEPTH);
      else
         return len[ADDR_W:0];
   endfunction
endpackage

// File: rtl/sort_verifier_if.sv
// rtl/sort_verifier_if.sv - request, RAM read port and result bundle of the sort verifier
interface sort_verifier_if;
   import sort_pkg::*;

   logic              start;
   logic [LEN_W-1:0]  len;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rden;
   logic [DATA_W-1:0] mem_q;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_count;
   logic [ADDR_W-1:0] first_err_idx;
   logic [SUM_W-1:0]  checksum;
   logic [DATA_W-1:0] min_val;
   logic [DATA_W-1:0] max_val;

   modport master (
      output start, len, mem_q,
      input  mem_addr, mem_rden, busy, done, pass, err_count,
             first_err_idx, checksum, min_val, max_val
   );

   modport slave (
      input  start, len, mem_q,
      output mem_addr, mem_rden, busy, done, pass, err_count,
             first_err_idx, checksum, min_val, max_val
   );
endinterface

// File: rtl/sort_verifier.sv
// rtl/sort_verifier.sv - scans the sorted RAM, checks ordering and accumulates checksum/min/max
module sort_verifier
   import sort_pkg::*;
(
   input  logic           CLOCK_50,
   input  logic           rst_n,
   sort_verifier_if.slave bus
);

   ver_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic              rden_q, rden_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [DATA_W-1:0] min_q, min_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic              pass_q, pass_d;
   logic [ADDR_W:0]   n_w;
   logic [ADDR_W:0]   n_m1;

   assign n_w  = clamp_len(bus.len);
   assign n_m1 = n_w - 1'b1;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         state_q <= VER_IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         rden_q  <= 1'b0;
         vld_q   <= 1'b0;
         prev_q  <= '0;
         idx_q   <= '0;
         err_q   <= '0;
         first_q <= '0;
         sum_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         rden_q  <= rden_d;
         vld_q   <= vld_d;
         prev_q  <= prev_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         first_q <= first_d;
         sum_q   <= sum_d;
         min_q   <= min_d;
         max_q   <= max_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      rden_d  = rden_q;
      vld_d   = rden_q;
      prev_d  = prev_q;
      idx_d   = idx_q;
      err_d   = err_q;
      first_d = first_q;
      sum_d   = sum_q;
      min_d   = min_q;
      max_d   = max_q;
      pass_d  = pass_q;

      // vld_q marks the cycle in which mem_q holds the word addressed one cycle earlier.
      if (vld_q) begin
         sum_d  = sum_q + SUM_W'(bus.mem_q);
         prev_d = bus.mem_q;
         idx_d  = idx_q + 1'b1;
         if (bus.mem_q < min_q) min_d = bus.mem_q;
         if (bus.mem_q > max_q) max_d = bus.mem_q;
         if ((idx_q != '0) && (bus.mem_q < prev_q)) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) first_d = idx_q;
         end
      end

      case (state_q)
         VER_IDLE, VER_DONE: begin
            if (bus.start) begin
               sum_d   = '0;
               err_d   = '0;
               first_d = '0;
               idx_d   = '0;
               pass_d  = 1'b0;
               addr_d  = '0;
               if (n_w == '0) begin
                  // Empty scan still takes one cycle through DRAIN so done timing is uniform.
                  state_d = VER_DRAIN;
                  min_d   = '0;
                  max_d   = '0;
               end else begin
                  state_d = VER_ISSUE;
                  rden_d  = 1'b1;
                  last_d  = n_m1[ADDR_W-1:0];
                  min_d   = '1;
                  max_d   = '0;
               end
            end
         end
         VER_ISSUE: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == last_q) begin
               state_d = VER_DRAIN;
               rden_d  = 1'b0;
            end
         end
         VER_DRAIN: begin
            if (!vld_q) begin
               state_d = VER_DONE;
               pass_d  = (err_q == '0);
            end
         end
         default: state_d = VER_IDLE;
      endcase
   end

   assign bus.mem_addr      = addr_q;
   assign bus.mem_rden      = rden_q;
   assign bus.busy          = (state_q == VER_ISSUE) || (state_q == VER_DRAIN);
   assign bus.done          = (state_q == VER_DONE);
   assign bus.pass          = pass_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_idx = first_q;
   assign bus.checksum      = sum_q;
   assign bus.min_val       = min_q;
   assign bus.max_val       = max_q;

endmodule

// File: tb/tb_sort_verifier.sv
// tb/tb_sort_verifier.sv - randomized and directed scans of sort_verifier against an array model
module tb_sort_verifier;
   import sort_pkg::*;

   logic CLOCK_50;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   n_reads;
   logic [7:0] ram [256];

   sort_verifier_if bus();

   sort_verifier dut (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // Synchronous RAM: data for the address presented in a cycle appears in the next one.
   always @(posedge CLOCK_50) begin
      bus.mem_q <= ram[bus.mem_addr];
      if (bus.mem_rden) n_reads++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int mode);
      int v;
      v = 0;
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0: ram[i] = 8'(i);
            1: ram[i] = 8'(255 - i);
            2: ram[i] = (i == 10) ? 8'd11 : (i == 11) ? 8'd10 : 8'(i);
            3: ram[i] = 8'h55;
            4: ram[i] = 8'($urandom_range(0, 255));
            5: begin
               v = v + int'($urandom_range(0, 2));
               if (v > 255) v = 255;
               ram[i] = 8'(v);
            end
            default: ram[i] = (i == 0) ? 8'h42 : 8'(i);
         endcase
      end
   endtask

   task automatic run_scan(input int len_in, input bit poke);
      int n, cyc, errs, first, sum, mn, mx, lat;
      n = (len_in > 256) ? 256 : len_in;
      errs = 0; first = 0; sum = 0; mx = 0;
      mn = (n == 0) ? 0 : 255;
      for (int i = 0; i < n; i++) begin
         sum = sum + ram[i];
         if (ram[i] < mn) mn = ram[i];
         if (ram[i] > mx) mx = ram[i];
         if (i > 0 && ram[i] < ram[i-1]) begin
            if (errs == 0) first = i;
            errs++;
         end
      end
      if (errs > 255) errs = 255;
      lat = (n == 0) ? 1 : n + 2;

      @(posedge CLOCK_50); #1;
      n_reads = 0;
      bus.len = 10'(len_in);
      bus.start = 1'b1;
      @(posedge CLOCK_50); #1;
      bus.start = 1'b0;
      bus.len = 10'($urandom_range(0, 1023));
      check("busy_after_start", 32'(bus.busy), 1);
      check("done_cleared", 32'(bus.done), 0);
      cyc = 0;
      while (!bus.done && cyc < 2000) begin
         @(posedge CLOCK_50); #1;
         cyc++;
         bus.start = 1'b0;
         if (poke && cyc == 50) begin
            bus.start = 1'b1;
            bus.len = 10'd3;
         end
      end
      check("done_seen", 32'(bus.done), 1);
      check("latency", 32'(cyc), 32'(lat));
      check("reads", 32'(n_reads), 32'(n));
      check("busy_at_done", 32'(bus.busy), 0);
      check("pass", 32'(bus.pass), (errs == 0) ? 1 : 0);
      check("err_count", 32'(bus.err_count), 32'(errs));
      check("first_err_idx", 32'(bus.first_err_idx), 32'(first));
      check("checksum", 32'(bus.checksum), 32'(sum & 16'hFFFF));
      check("min_val", 32'(bus.min_val), 32'(mn));
      check("max_val", 32'(bus.max_val), 32'(mx));
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("checksum_hold", 32'(bus.checksum), 32'(sum & 16'hFFFF));
      check("done_hold", 32'(bus.done), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"}, 32'(bus.mem_addr), 0);
      check({tag, "_rden"}, 32'(bus.mem_rden), 0);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
      check({tag, "_pass"}, 32'(bus.pass), 0);
      check({tag, "_err"}, 32'(bus.err_count), 0);
      check({tag, "_first"}, 32'(bus.first_err_idx), 0);
      check({tag, "_sum"}, 32'(bus.checksum), 0);
      check({tag, "_min"}, 32'(bus.min_val), 0);
      check({tag, "_max"}, 32'(bus.max_val), 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      n_reads = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.len = '0;
      for (int i = 0; i < 256; i++) ram[i] = '0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      fill(0); run_scan(256, 1'b1);
      fill(1); run_scan(256, 1'b0);
      fill(2); run_scan(256, 1'b0);
      fill(3); run_scan(256, 1'b0);
      run_scan(0, 1'b0);
      fill(6); run_scan(1, 1'b0);
      fill(0); run_scan(300, 1'b0);

      // Abort a scan with reset partway through; no partial result may survive.
      fill(1);
      @(posedge CLOCK_50); #1;
      bus.len = 10'd256;
      bus.start = 1'b1;
      @(posedge CLOCK_50); #1;
      bus.start = 1'b0;
      repeat (100) @(posedge CLOCK_50);
      #1;
      rst_n = 1'b0;
      @(posedge CLOCK_50); #1;
      check_all_zero("midreset");
      rst_n = 1'b1;
      @(posedge CLOCK_50); #1;
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_done", 32'(bus.done), 0);
      run_scan(256, 1'b0);

      for (int k = 0; k < 8; k++) begin
         fill((k % 2 == 0) ? 5 : 4);
         run_scan(int'($urandom_range(0, 300)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
